// File: rtl/uart_pkg.sv
// Shared constants and types for the UART transmit queue.
//   DEFAULT_DATA_WIDTH : default character width
//   DEFAULT_DEPTH      : default number of queued characters
//   tx_state_e         : launch FSM states
package uart_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 8;
  localparam int unsigned DEFAULT_DEPTH      = 8;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StWaitBusy = 2'd1,
    StWaitDone = 2'd2
  } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous circular-buffer FIFO with flush.
//   clk, rst       : clock, synchronous active-high reset
//   flush          : empty the FIFO next cycle; blocks push and pop this cycle
//   push/push_data : write request; ignored while full or flushing
//   pop            : read request; ignored while empty or flushing
//   head_data      : oldest entry (valid when !empty)
//   count          : number of stored entries, 0..DEPTH
//   empty, full    : count == 0, count == DEPTH
module sync_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned DEPTH      = DEFAULT_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic [DATA_WIDTH-1:0]      push_data,
  input  logic                       pop,
  output logic [DATA_WIDTH-1:0]      head_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full
);

  localparam int unsigned PtrW   = $clog2(DEPTH);
  localparam int unsigned CountW = PtrW + 1;
  localparam logic [CountW-1:0] FullCount = CountW'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CountW-1:0]     count_q;
  logic                  do_push, do_pop;

  assign empty     = (count_q == '0);
  assign full      = (count_q == FullCount);
  assign count     = count_q;
  assign head_data = mem[rd_ptr_q];

  // Full blocks a push even when a pop frees a slot in the same cycle.
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  // DEPTH is a power of two, so pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Character queue in front of a UART transmitter with a launch FSM.
//   clk, rst           : clock, synchronous active-high reset
//   in_data/in_valid   : upstream character and its valid
//   in_ready           : character accepted this cycle (!full && !flush)
//   flush              : discard queued characters (in-flight frame unaffected)
//   tx_data, tx_en     : registered character and one-cycle launch strobe
//   tx_busy, tx_done   : transmitter busy level and frame-complete pulse
//   fifo_count         : queued characters, 0..DEPTH
//   empty, full        : queue status
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned DEPTH      = DEFAULT_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_WIDTH-1:0]  in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   flush,
  output logic [DATA_WIDTH-1:0]  tx_data,
  output logic                   tx_en,
  input  logic                   tx_busy,
  input  logic                   tx_done,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   empty,
  output logic                   full
);

  tx_state_e             state_q;
  logic                  tx_en_q;
  logic [DATA_WIDTH-1:0] tx_data_q;
  logic [DATA_WIDTH-1:0] head_data;
  logic                  push, pop;

  assign in_ready = !full && !flush;
  assign push     = in_valid && in_ready;
  // A flush in IDLE suppresses the pop, so a discarded character is never launched.
  assign pop      = (state_q == StIdle) && !empty && !flush;

  sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (push),
    .push_data (in_data),
    .pop       (pop),
    .head_data (head_data),
    .count     (fifo_count),
    .empty     (empty),
    .full      (full)
  );

  // Busy/done are only looked at in the wait states, so leftovers from a
  // frame interrupted by reset are ignored in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      tx_en_q   <= 1'b0;
      tx_data_q <= '0;
    end else begin
      tx_en_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (pop) begin
            tx_data_q <= head_data;
            tx_en_q   <= 1'b1;
            state_q   <= StWaitBusy;
          end
        end
        StWaitBusy: if (tx_busy) state_q <= StWaitDone;
        StWaitDone: if (tx_done) state_q <= StIdle;
        default:    state_q <= StIdle;
      endcase
    end
  end

  assign tx_en   = tx_en_q;
  assign tx_data = tx_data_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          flush = 1'b0;
  logic [DW-1:0] tx_data;
  logic          tx_en;
  logic          tx_busy = 1'b0;
  logic          tx_done = 1'b0;
  logic [CW-1:0] fifo_count;
  logic          empty, full;

  int tests_run  = 0;
  int fail_count = 0;

  always #5 clk = ~clk;

  uart_tx_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .flush      (flush),
    .tx_data    (tx_data),
    .tx_en      (tx_en),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .fifo_count (fifo_count),
    .empty      (empty),
    .full       (full)
  );

  // Transmitter model: busy from the cycle after tx_en, done pulse when the
  // frame ends. xmt_hold freezes it busy. It is not reset with the DUT.
  logic xmt_hold = 1'b0;
  int   xmt_len  = 2;
  logic xmt_active = 1'b0;
  int   xmt_left = 0;

  always @(posedge clk) begin
    tx_done <= 1'b0;
    if (!xmt_active) begin
      if (tx_en === 1'b1) begin
        xmt_active <= 1'b1;
        tx_busy    <= 1'b1;
        xmt_left   <= xmt_len;
      end
    end else if (!xmt_hold) begin
      if (xmt_left == 0) begin
        xmt_active <= 1'b0;
        tx_busy    <= 1'b0;
        tx_done    <= 1'b1;
      end else begin
        xmt_left <= xmt_left - 1;
      end
    end
  end

  // Launch log: every tx_en cycle records the character it carried.
  logic [DW-1:0] launched[$];
  int   en_double   = 0;
  int   done_pulses = 0;
  logic en_prev     = 1'b0;

  always @(posedge clk) begin
    if (tx_en === 1'b1) launched.push_back(tx_data);
    if (tx_en === 1'b1 && en_prev) en_double++;
    if (tx_done) done_pulses++;
    en_prev = (tx_en === 1'b1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    xmt_hold = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (!xmt_active && empty && !tx_en && !tx_busy) break;
      tick();
    end
    repeat (3) tick();
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (tx_done) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  // Launch one character and leave the transmitter stuck busy with it,
  // so the FSM sits in WAIT_DONE.
  task automatic start_held_frame(input logic [DW-1:0] ch);
    xmt_hold = 1'b1;
    in_data  = ch;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
  endtask

  task automatic push_seq(input logic [DW-1:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      in_data  = first + DW'(i);
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    tests_run++;
    if (tx_en !== 1'b0 || tx_data !== '0) begin
      fail_count++;
      $display("FAIL reset_tx: tx_en=%b tx_data=%h, required 0/00", tx_en, tx_data);
    end
    tests_run++;
    if (fifo_count !== '0 || empty !== 1'b1 || full !== 1'b0 || in_ready !== 1'b1) begin
      fail_count++;
      $display("FAIL reset_status: count=%0d empty=%b full=%b in_ready=%b, required 0/1/0/1",
               fifo_count, empty, full, in_ready);
    end
    rst = 1'b0;
    repeat (2) tick();
    tests_run++;
    if (tx_en !== 1'b0 || empty !== 1'b1) begin
      fail_count++;
      $display("FAIL reset_idle: tx_en=%b empty=%b, required 0/1", tx_en, empty);
    end
  endtask

  task automatic test_single();
    int base = launched.size();
    in_data  = 8'hA5;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tests_run++;
    if (tx_en !== 1'b0 || fifo_count !== CW'(1)) begin
      fail_count++;
      $display("FAIL single_queued: tx_en=%b count=%0d, required 0/1", tx_en, fifo_count);
    end
    tick();
    tests_run++;
    if (tx_en !== 1'b1 || tx_data !== 8'hA5 || fifo_count !== '0) begin
      fail_count++;
      $display("FAIL single_launch: tx_en=%b data=%h count=%0d, required 1/a5/0",
               tx_en, tx_data, fifo_count);
    end
    tick();
    tests_run++;
    if (tx_en !== 1'b0 || tx_data !== 8'hA5) begin
      fail_count++;
      $display("FAIL single_hold: tx_en=%b data=%h, required 0/a5", tx_en, tx_data);
    end
    settle();
    tests_run++;
    if (launched.size() - base != 1) begin
      fail_count++;
      $display("FAIL single_pulses: %0d pulses, required 1", launched.size() - base);
    end
  endtask

  task automatic test_order_full();
    int base;
    int dbl = en_double;
    start_held_frame(8'hEE);
    base = launched.size();
    push_seq(8'h01, 8);
    tests_run++;
    if (full !== 1'b1 || in_ready !== 1'b0 || fifo_count !== CW'(8)) begin
      fail_count++;
      $display("FAIL full_flags: full=%b in_ready=%b count=%0d, required 1/0/8",
               full, in_ready, fifo_count);
    end
    in_data  = 8'h99;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tests_run++;
    if (fifo_count !== CW'(8)) begin
      fail_count++;
      $display("FAIL full_no_push: count=%0d, required 8", fifo_count);
    end
    settle();
    tests_run++;
    if (launched.size() - base != 8) begin
      fail_count++;
      $display("FAIL order_pulses: %0d pulses, required 8", launched.size() - base);
    end else begin
      for (int i = 0; i < 8; i++) begin
        tests_run++;
        if (launched[base+i] !== DW'(i + 1)) begin
          fail_count++;
          $display("FAIL order_char%0d: got %h, required %h", i, launched[base+i], i + 1);
        end
      end
    end
    tests_run++;
    if (en_double != dbl) begin
      fail_count++;
      $display("FAIL order_en_width: %0d multi-cycle tx_en, required 0", en_double - dbl);
    end
  endtask

  task automatic test_back_to_back();
    int base;
    bit ok;
    start_held_frame(8'h30);
    base = launched.size();
    push_seq(8'h31, 2);
    xmt_hold = 1'b0;
    for (int k = 0; k < 2; k++) begin
      wait_done(50, ok);
      tests_run++;
      if (!ok) begin
        fail_count++;
        $display("FAIL b2b_done%0d: no tx_done within 50 cycles, required one", k);
      end
      tick();
      tests_run++;
      if (tx_en !== 1'b0) begin
        fail_count++;
        $display("FAIL b2b_gap%0d: tx_en=%b at M+1, required 0", k, tx_en);
      end
      tick();
      tests_run++;
      if (tx_en !== 1'b1 || tx_data !== DW'(8'h31 + k)) begin
        fail_count++;
        $display("FAIL b2b_launch%0d: tx_en=%b data=%h at M+2, required 1/%h",
                 k, tx_en, tx_data, 8'h31 + k);
      end
    end
    settle();
    tests_run++;
    if (launched.size() - base != 2) begin
      fail_count++;
      $display("FAIL b2b_pulses: %0d pulses, required 2", launched.size() - base);
    end
  endtask

  task automatic test_simul_push_pop();
    int base;
    bit ok;
    start_held_frame(8'h40);
    base = launched.size();
    push_seq(8'h41, 3);
    xmt_hold = 1'b0;
    wait_done(50, ok);
    tick();
    in_data  = 8'h44;
    in_valid = 1'b1;
    #1;
    tests_run++;
    if (!ok || fifo_count !== CW'(3) || in_ready !== 1'b1) begin
      fail_count++;
      $display("FAIL simul_setup: done_seen=%b count=%0d in_ready=%b, required 1/3/1",
               ok, fifo_count, in_ready);
    end
    tick();
    in_valid = 1'b0;
    tests_run++;
    if (tx_en !== 1'b1 || tx_data !== 8'h41 || fifo_count !== CW'(3)) begin
      fail_count++;
      $display("FAIL simul_pushpop: tx_en=%b data=%h count=%0d, required 1/41/3",
               tx_en, tx_data, fifo_count);
    end
    settle();
    tests_run++;
    if (launched.size() - base != 4) begin
      fail_count++;
      $display("FAIL simul_pulses: %0d pulses, required 4", launched.size() - base);
    end else begin
      for (int i = 0; i < 4; i++) begin
        tests_run++;
        if (launched[base+i] !== DW'(8'h41 + i)) begin
          fail_count++;
          $display("FAIL simul_char%0d: got %h, required %h", i, launched[base+i], 8'h41 + i);
        end
      end
    end
  endtask

  task automatic test_flush();
    int base, dp;
    start_held_frame(8'h50);
    base = launched.size();
    push_seq(8'h51, 5);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h66;
    #1;
    tests_run++;
    if (in_ready !== 1'b0 || fifo_count !== CW'(5)) begin
      fail_count++;
      $display("FAIL flush_ready: in_ready=%b count=%0d, required 0/5", in_ready, fifo_count);
    end
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    tests_run++;
    if (fifo_count !== '0 || empty !== 1'b1) begin
      fail_count++;
      $display("FAIL flush_clear: count=%0d empty=%b, required 0/1", fifo_count, empty);
    end
    dp = done_pulses;
    xmt_hold = 1'b0;
    repeat (30) tick();
    tests_run++;
    if (done_pulses - dp != 1 || launched.size() != base || tx_data !== 8'h50) begin
      fail_count++;
      $display("FAIL flush_after: done=%0d launches=%0d data=%h, required 1/0/50",
               done_pulses - dp, launched.size() - base, tx_data);
    end
  endtask

  task automatic test_reset_mid_frame();
    int base;
    start_held_frame(8'h70);
    push_seq(8'h71, 4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests_run++;
    if (tx_en !== 1'b0 || empty !== 1'b1 || fifo_count !== '0 || tx_data !== '0) begin
      fail_count++;
      $display("FAIL rstmid_state: tx_en=%b empty=%b count=%0d data=%h, required 0/1/0/00",
               tx_en, empty, fifo_count, tx_data);
    end
    base = launched.size();
    xmt_hold = 1'b0;
    repeat (30) tick();
    tests_run++;
    if (launched.size() != base) begin
      fail_count++;
      $display("FAIL rstmid_nolaunch: %0d launches, required 0", launched.size() - base);
    end
    in_data  = 8'h7A;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tests_run++;
    if (tx_en !== 1'b1 || tx_data !== 8'h7A) begin
      fail_count++;
      $display("FAIL rstmid_relaunch: tx_en=%b data=%h, required 1/7a", tx_en, tx_data);
    end
    settle();
  endtask

  // Reference: a queue of accepted-but-unlaunched characters plus a note of
  // whether the transmitter link is free (no frame launched and not yet done).
  task automatic test_random();
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] exp_head, d;
    int   link;  // 0 free, 1 launched awaiting busy, 2 awaiting done
    int   pct;
    logic v, f, b, dn, launch, accept, exp_ready;
    settle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    link = 0;
    exp_head = '0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      pct      = (cyc < 300) ? 75 : ((cyc < 600) ? 30 : 0);
      in_valid = ($urandom_range(0, 99) < pct);
      in_data  = DW'($urandom);
      flush    = (cyc < 600) && ($urandom_range(0, 19) == 0);
      xmt_len  = $urandom_range(0, 3);
      #1;
      exp_ready = (exp_q.size() < DEPTH) && !flush;
      tests_run++;
      if (in_ready !== exp_ready) begin
        fail_count++;
        $display("FAIL rnd_ready c%0d: got %b, required %b", cyc, in_ready, exp_ready);
      end
      v = in_valid; d = in_data; f = flush; b = tx_busy; dn = tx_done;
      launch = (link == 0) && (exp_q.size() > 0) && !f;
      accept = v && (exp_q.size() < DEPTH) && !f;
      if (launch) exp_head = exp_q[0];
      tick();
      if (link == 1 && b) link = 2;
      else if (link == 2 && dn) link = 0;
      if (launch) link = 1;
      if (f) exp_q.delete();
      else begin
        if (launch) void'(exp_q.pop_front());
        if (accept) exp_q.push_back(d);
      end
      tests_run++;
      if (tx_en !== launch || (launch && tx_data !== exp_head)) begin
        fail_count++;
        $display("FAIL rnd_launch c%0d: tx_en=%b data=%h, required %b/%h",
                 cyc, tx_en, tx_data, launch, exp_head);
      end
      tests_run++;
      if (fifo_count !== CW'(exp_q.size()) || empty !== (exp_q.size() == 0) ||
          full !== (exp_q.size() == DEPTH)) begin
        fail_count++;
        $display("FAIL rnd_count c%0d: count=%0d empty=%b full=%b, required %0d",
                 cyc, fifo_count, empty, full, exp_q.size());
      end
    end
    in_valid = 1'b0;
    flush    = 1'b0;
    settle();
  endtask

  initial begin
    test_reset();
    test_single();
    test_order_full();
    test_back_to_back();
    test_simul_push_pop();
    test_flush();
    test_reset_mid_frame();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of each queued character; matches the UART transmitter data width.
REQ-002 Parameter DEPTH, default 8, number of FIFO entries; power of two, at least 2.
REQ-003 Port clk  input  1  single clock for all logic.
REQ-004 Port rst  input  1  reset, synchronous and active-high.
REQ-005 Port in_data  input  DATA_WIDTH  character offered by the upstream producer.
REQ-006 Port in_valid  input  1  in_data is valid this cycle.
REQ-007 Port in_ready  output  1  FIFO accepts in_data this cycle.
REQ-008 Port flush  input  1  discard all queued characters.
REQ-009 Port tx_data  output  DATA_WIDTH  character presented to the transmitter data input.
REQ-010 Port tx_en  output  1  one-cycle launch strobe to the transmitter enable input.
REQ-011 Port tx_busy  input  1  transmitter busy flag.
REQ-012 Port tx_done  input  1  transmitter frame-complete pulse.
REQ-013 Port fifo_count  output  $clog2(DEPTH)+1  number of queued characters, 0..DEPTH.
REQ-014 Port empty  output  1  fifo_count == 0.
REQ-015 Port full  output  1  fifo_count == DEPTH.

Function
REQ-016 The FIFO SHALL be a circular buffer with read and write pointers that wrap modulo DEPTH.
REQ-017 The FIFO SHALL perform a push when in_valid && in_ready; in_ready SHALL be !full && !flush, combinational from registered state.
REQ-018 While full, in_ready SHALL be 0 even if a pop occurs in the same cycle; a push on a full FIFO SHALL never happen.
REQ-019 A push and a pop in the same cycle SHALL leave fifo_count unchanged and keep both data items correct.
REQ-020 The launch FSM SHALL have three states: IDLE, WAIT_BUSY and WAIT_DONE.
REQ-021 IDLE, when !empty: pop the head entry into the tx_data register, set tx_en to 1 for the next cycle, and go to WAIT_BUSY.
REQ-022 IDLE, when empty: stay in IDLE with tx_en at 0.
REQ-023 WAIT_BUSY: tx_en SHALL return to 0 and the FSM SHALL stay until tx_busy == 1, then go to WAIT_DONE.
REQ-024 WAIT_DONE: the FSM SHALL stay until tx_done == 1, then go to IDLE.
REQ-025 tx_en SHALL be a registered output that is high for exactly one cycle per popped character.
REQ-026 tx_data SHALL hold its value from the tx_en cycle until the next launch.
REQ-027 Latency: a push at cycle N into an empty FIFO, with the FSM in IDLE, SHALL produce tx_en high at cycle N+1 carrying that character.
REQ-028 Back-to-back frames: tx_done seen at cycle M SHALL give IDLE at M+1 and the next tx_en at M+2 when the FIFO is not empty.
REQ-029 A push that occurs in the cycle tx_en rises SHALL be visible to the FSM no earlier than the following IDLE state.
REQ-030 Flush SHALL reset both pointers and fifo_count to 0 in the next cycle.
REQ-031 Flush SHALL win over a simultaneous push, and a simultaneous pop in IDLE SHALL be suppressed.
REQ-032 Flush SHALL NOT alter the FSM state, tx_data, or a character already launched.
REQ-033 Characters SHALL leave the FIFO in strict arrival order.

Reset
REQ-034 On rst the block SHALL clear both pointers, set fifo_count to 0, put the FSM in IDLE, and drive tx_en 0 and tx_data 0.
REQ-035 Immediately after reset, empty SHALL be 1, full 0 and in_ready 1.
REQ-036 Reset SHALL take priority over all other inputs, including in the middle of a frame.
REQ-037 After reset the FSM SHALL ignore any tx_busy or tx_done left over from a frame in flight.
REQ-038 The storage array itself SHALL NOT need to be reset.

Structure
REQ-039 The FSM state enum and the default DATA_WIDTH/DEPTH constants SHALL be placed in the shared package uart_pkg.
REQ-040 The storage and pointer logic SHALL be one sub-module, sync_fifo, parameterised by DATA_WIDTH and DEPTH; the launch FSM SHALL sit in uart_tx_fifo.
REQ-041 The block SHALL connect directly to the UART transmitter: tx_data to its data input, tx_en to its enable, and its busy and done outputs back to tx_busy and tx_done.

Verification
REQ-042 Single character: push 0xA5 into an empty FIFO at cycle N -> tx_en high only at N+1, tx_data=0xA5, fifo_count returns to 0.
REQ-043 Order and full: push 8 characters 0x01..0x08 with the transmitter held busy -> full=1 and in_ready=0; after releasing, the transmitter sees 0x01..0x08 in order, exactly 8 tx_en pulses.
REQ-044 Back-to-back: with tx_done pulsed at cycle M and 2 characters queued -> next tx_en at M+2, no gaps or duplicates.
REQ-045 Simultaneous push/pop: push during the IDLE pop cycle with fifo_count=3 -> fifo_count remains 3 and data order is preserved.
REQ-046 Flush: flush with 5 queued characters and one in flight -> fifo_count=0 next cycle, the in-flight frame completes, and no further tx_en follows.
REQ-047 Reset mid-frame: rst asserted in WAIT_DONE with 4 queued characters -> next cycle FSM in IDLE, tx_en=0, empty=1, and no launch until a new push.
